// File: rtl/polar_pkg.sv
// Shared polar-code types, counter sizing helper and frozen-mask constants
// used by both the encoder and the decoder.
package polar_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    ENCODE = 2'd1,
    OUTPUT = 2'd2
  } enc_state_t;

  // Width of a counter that indexes 0..n-1; never narrower than one bit.
  function automatic int counter_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Bit i = 1 marks u[i] as frozen to zero.
  localparam logic [7:0]  FROZEN_MASK_N8_K4  = 8'b0001_0111;
  localparam logic [15:0] FROZEN_MASK_N16_K8 = 16'h017F;

endpackage

// File: rtl/polar_butterfly_stage.sv
// One butterfly layer of x = u * F^(xn): for every i with bit s clear,
// v[i] ^= v[i + 2^s]. Stage is selected at run time so one network serves all n layers.
module polar_butterfly_stage
  import polar_pkg::*;
#(
  parameter int CODE_LENGTH = 1024,
  localparam int LOG_N = $clog2(CODE_LENGTH),
  localparam int IDX_W = counter_width(CODE_LENGTH),
  localparam int STG_W = counter_width(LOG_N) + 1
) (
  input  logic [CODE_LENGTH-1:0] i_vec,
  input  logic [STG_W-1:0]       i_stage,
  output logic [CODE_LENGTH-1:0] o_vec
);

  logic [CODE_LENGTH-1:0] w_partner;

  // Each position picks its stage-dependent partner, then a single XOR per bit.
  always_comb begin
    w_partner = '0;
    for (int i = 0; i < CODE_LENGTH; i++) begin
      for (int s = 0; s < LOG_N; s++) begin
        if ((i_stage == STG_W'(s)) && (((i >> s) & 1) == 0)) begin
          w_partner[IDX_W'(i)] = i_vec[IDX_W'(i | (1 << s))];
        end
      end
    end
  end

  assign o_vec = i_vec ^ w_partner;

endmodule

// File: rtl/polar_encoder.sv
// Bit-serial polar encoder: loads info bits around frozen zeros, runs n butterfly
// layers in place, then streams the codeword out index 0 first.
module polar_encoder
  import polar_pkg::*;
#(
  parameter int CODE_LENGTH        = 1024,
  parameter int FROZEN_BITS_LENGTH = 48,
  parameter logic [CODE_LENGTH-1:0] FROZEN_MASK =
    {{(CODE_LENGTH-FROZEN_BITS_LENGTH){1'b0}}, {FROZEN_BITS_LENGTH{1'b1}}}
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_bit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy,
  output enc_state_t dbg_state
);

  localparam int N     = CODE_LENGTH;
  localparam int LOG_N = $clog2(N);
  localparam int IDX_W = counter_width(N);
  localparam int STG_W = counter_width(LOG_N) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N - 1);
  localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(LOG_N - 1);

  if ((N < 4) || ((N & (N - 1)) != 0)) begin : g_bad_length
    $error("polar_encoder: CODE_LENGTH must be a power of 2 and >= 4");
  end
  if ($countones(FROZEN_MASK) != FROZEN_BITS_LENGTH) begin : g_bad_mask
    $error("polar_encoder: FROZEN_BITS_LENGTH must equal popcount(FROZEN_MASK)");
  end

  enc_state_t       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [STG_W-1:0] r_stage, w_stage_nxt;
  logic [N-1:0]     r_vec, w_vec_nxt, w_vec_bfly;
  logic             w_frozen;

  assign w_frozen = FROZEN_MASK[r_idx];

  polar_butterfly_stage #(.CODE_LENGTH(N)) u_bfly (
    .i_vec   (r_vec),
    .i_stage (r_stage),
    .o_vec   (w_vec_bfly)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= LOAD;
      r_idx   <= '0;
      r_stage <= '0;
      r_vec   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_stage <= w_stage_nxt;
      r_vec   <= w_vec_nxt;
    end
  end

  // Handshake: a bit moves on a rising edge where valid && ready; the producer
  // holds data stable until then, and out_valid never drops before acceptance.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_stage_nxt = r_stage;
    w_vec_nxt   = r_vec;
    in_ready    = 1'b0;
    case (r_state)
      LOAD: begin
        in_ready = !w_frozen;
        // Frozen slots advance on their own, one cycle each.
        if (w_frozen || in_valid) begin
          w_vec_nxt[r_idx] = w_frozen ? 1'b0 : in_bit;
          if (r_idx == LAST_IDX) begin
            w_idx_nxt   = '0;
            w_stage_nxt = '0;
            w_state_nxt = ENCODE;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      ENCODE: begin
        w_vec_nxt = w_vec_bfly;
        if (r_stage == LAST_STAGE) begin
          w_stage_nxt = '0;
          w_idx_nxt   = '0;
          w_state_nxt = OUTPUT;
        end else begin
          w_stage_nxt = r_stage + STG_W'(1);
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          if (r_idx == LAST_IDX) begin
            w_idx_nxt   = '0;
            w_state_nxt = LOAD;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  assign out_valid = (r_state == OUTPUT);
  assign out_bit   = out_valid & r_vec[r_idx];
  assign out_last  = out_valid && (r_idx == LAST_IDX);
  assign busy      = (r_state != LOAD);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_polar_encoder.sv
// Scoreboard bench for polar_encoder (N=8, info indices 3,5,6,7): directed
// codewords, back-to-back timing, handshake stalls and reset abort.
module tb_polar_encoder;
  import polar_pkg::*;

  localparam int N = 8;
  localparam int K = 4;
  localparam logic [N-1:0] MASK = FROZEN_MASK_N8_K4;

  logic       clk, reset, in_bit, in_valid, out_ready;
  logic       in_ready, out_bit, out_valid, out_last, busy;
  enc_state_t dbg_state;

  int         checks = 0;
  int         failures = 0;
  logic [1:0] exp_q[$];
  int         cyc = 0;
  int         out_cnt = 0;
  int         last_edge = -100;
  int         acc4_edge = -100;
  bit         measure_lat = 0;
  bit         rdy_random = 0;
  bit         prev_stall = 0;
  bit         prev_valid = 0;
  logic       stall_bit, stall_last;

  polar_encoder #(
    .CODE_LENGTH        (N),
    .FROZEN_BITS_LENGTH (4),
    .FROZEN_MASK        (MASK)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // x[j] = XOR of u[i] over every i whose bits cover j.
  function automatic logic [N-1:0] ref_encode(input logic [K-1:0] info);
    logic [N-1:0] u;
    logic [N-1:0] m;
    logic [N-1:0] x;
    int k;
    u = '0;
    m = MASK;
    k = 0;
    for (int i = 0; i < N; i++) begin
      if (!m[i]) begin
        u[i] = info[k];
        k++;
      end
    end
    for (int j = 0; j < N; j++) begin
      x[j] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if ((i & j) == j) x[j] = x[j] ^ u[i];
      end
    end
    return x;
  endfunction

  // ---------------- drivers ----------------
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_random ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_out_bit", int'(out_bit), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_state", int'(dbg_state), int'(LOAD));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Queues the expected codeword, then offers the K info bits in order.
  task automatic send_block(input logic [K-1:0] info, input logic [N-1:0] x, input bit gaps);
    int t;
    for (int j = 0; j < N; j++) exp_q.push_back({(j == N - 1) ? 1'b1 : 1'b0, x[j]});
    for (int k = 0; k < K; k++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
        in_bit = 1'($urandom);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      in_bit = info[k];
      in_valid = 1'b1;
      t = 0;
      forever begin
        @(negedge clk);
        t++;
        if (in_ready) begin
          if (k == K - 1) acc4_edge = cyc + 1;
          break;
        end
        if (t > 300) begin
          check("in_ready_timeout", int'(in_ready), 1);
          break;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0) && (t < 500)) begin
      @(negedge clk);
      t++;
    end
    #1;
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : mon
    logic [1:0] e;
    int d;
    if (!reset) begin
      prev_stall = 0;
      prev_valid = 0;
      last_edge = -100;
    end else begin
      d = cyc - last_edge;
      if ((d >= 0) && (d <= 3)) check("in_ready_after_last", int'(in_ready), int'(d == 3));
      if (measure_lat && out_valid && !prev_valid)
        check("first_valid_latency", cyc - acc4_edge, 3);
      if (prev_stall) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_bit", int'(out_bit), int'(stall_bit));
        check("stall_last", int'(out_last), int'(stall_last));
      end
      if (out_valid) begin
        check("busy_with_valid", int'(busy), 1);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: got bit %0d with empty expected queue", out_bit);
          end else begin
            e = exp_q.pop_front();
            check("out_bit", int'(out_bit), int'(e[0]));
            check("out_last", int'(out_last), int'(e[1]));
            out_cnt++;
            if (out_last) last_edge = cyc + 1;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      stall_bit  = out_bit;
      stall_last = out_last;
      prev_valid = out_valid;
    end
  end

  // ---------------- stimulus ----------------
  initial begin : main
    logic [K-1:0] info;
    int base;
    int t;
    reset = 1'b0;
    in_bit = 1'b0;
    in_valid = 1'b0;
    do_reset();

    // Directed codewords (info order u3,u5,u6,u7 -> info[0..3]).
    send_block(4'b1101, 8'b1010_0101, 0);
    send_block(4'b1000, 8'b1111_1111, 0);
    send_block(4'b0001, 8'b0000_1111, 0);
    send_block(4'b0000, 8'b0000_0000, 0);
    in_valid = 1'b0;
    drain();

    // Back-to-back blocks: frozen prefill timing and encode latency.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("in_ready_after_reset", int'(in_ready), int'(c == 3));
    end
    @(posedge clk);
    #1;
    measure_lat = 1;
    for (int b = 0; b < 3; b++) begin
      info = K'($urandom_range(0, 15));
      send_block(info, ref_encode(info), 0);
    end
    in_valid = 1'b0;
    drain();
    measure_lat = 0;

    // Random blocks with input gaps and output back-pressure.
    rdy_random = 1;
    for (int b = 0; b < 12; b++) begin
      info = K'($urandom_range(0, 15));
      send_block(info, ref_encode(info), 1);
    end
    in_valid = 1'b0;
    drain();
    rdy_random = 0;

    // Reset pulsed after three codeword bits have been taken.
    base = out_cnt;
    send_block(4'b1101, 8'b1010_0101, 0);
    in_valid = 1'b0;
    t = 0;
    while ((out_cnt < base + 3) && (t < 200)) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("mid_output_progress", out_cnt - base, 3);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_out_last", int'(out_last), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_state", int'(dbg_state), int'(LOAD));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    send_block(4'b1101, 8'b1010_0101, 0);
    in_valid = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
